montador_operandos: RTL and testbench

Input-assembly stage that sits directly upstream of the 16-bit magnitude comparator in the datapath. It collects a player guess as four 4-bit digits (most significant digit first) into operand A and holds a target value in operand B. Once both are valid it presents them to the comparator with neutral cascade inputs. It then issues a one-cycle `comparar` strobe, which marks the cycle in which the comparator outputs are meaningful for the downstream control unit.

---
 rtl/montador_operandos.sv | 114 +++++++++++
 tb/tb_montador_operandos.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/montador_operandos.sv
`default_nettype none
// ============================================================================
// Module      : montador_operandos
// Description : Assembles a guess from 4-bit digits (MSD first) into A and
//               holds a target in B for a downstream magnitude comparator.
//               Raises pronto when both are valid and issues a one-cycle
//               comparar strobe when the comparator result becomes meaningful.
// Revision    : 1.0 - initial release
// ============================================================================
module montador_operandos #(
  parameter int NIBBLES = 4,
  localparam int W  = 4 * NIBBLES,
  localparam int CW = $clog2(NIBBLES + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          limpa,
  input  logic          carrega_alvo,
  input  logic [W-1:0]  alvo_in,
  input  logic [3:0]    digito,
  input  logic          digito_valido,
  output logic [W-1:0]  A,
  output logic [W-1:0]  B,
  output logic          ALBi,
  output logic          AGBi,
  output logic          AEBi,
  output logic          pronto,
  output logic          comparar,
  output logic [CW-1:0] contagem,
  output logic          erro
);

  typedef enum logic [1:0] {
    VAZIO     = 2'd0,
    RECEBENDO = 2'd1,
    COMPLETO  = 2'd2
  } estado_t;

  localparam logic [CW-1:0] ULTIMO_DIGITO = CW'(NIBBLES - 1);

  estado_t       estado, estado_n;
  logic [W-1:0]  a_n, b_n;
  logic [CW-1:0] contagem_n;
  logic          erro_n, alvo_ok, alvo_ok_n, pronto_n, comparar_n;

  // Neutral cascade: comparator reports the plain A-versus-B relation
  assign ALBi = 1'b0;
  assign AGBi = 1'b0;
  assign AEBi = 1'b1;

  // Next-state for guess entry, target load and the ready/strobe flags
  always_comb begin
    estado_n   = estado;
    a_n        = A;
    contagem_n = contagem;
    erro_n     = erro;
    b_n        = B;
    alvo_ok_n  = alvo_ok;

    if (limpa) begin
      // Clear wins over a digit arriving in the same cycle
      estado_n   = VAZIO;
      a_n        = '0;
      contagem_n = '0;
      erro_n     = 1'b0;
    end else if (digito_valido) begin
      case (estado)
        VAZIO, RECEBENDO: begin
          a_n        = {A[W-5:0], digito};
          contagem_n = contagem + CW'(1);
          estado_n   = (contagem == ULTIMO_DIGITO) ? COMPLETO : RECEBENDO;
        end
        default: begin
          // Surplus digit: keep the guess, flag overflow until cleared
          erro_n = 1'b1;
        end
      endcase
    end

    if (carrega_alvo) begin
      b_n       = alvo_in;
      alvo_ok_n = 1'b1;
    end

    pronto_n   = (estado_n == COMPLETO) && alvo_ok_n;
    // Strobe on the rising edge of pronto, or on a new target while ready
    comparar_n = pronto_n && (!pronto || carrega_alvo);
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= VAZIO;
      A        <= '0;
      B        <= '0;
      contagem <= '0;
      erro     <= 1'b0;
      alvo_ok  <= 1'b0;
      pronto   <= 1'b0;
      comparar <= 1'b0;
    end else begin
      estado   <= estado_n;
      A        <= a_n;
      B        <= b_n;
      contagem <= contagem_n;
      erro     <= erro_n;
      alvo_ok  <= alvo_ok_n;
      pronto   <= pronto_n;
      comparar <= comparar_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_montador_operandos.sv
`default_nettype none
// ============================================================================
// Module      : tb_montador_operandos
// Description : Directed self-checking bench for montador_operandos.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_montador_operandos;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        limpa = 1'b0;
  logic        carrega_alvo = 1'b0;
  logic [15:0] alvo_in = '0;
  logic [3:0]  digito = '0;
  logic        digito_valido = 1'b0;
  logic [15:0] A, B;
  logic        ALBi, AGBi, AEBi, pronto, comparar, erro;
  logic [2:0]  contagem;

  int n_cmp = 0;
  int n_err = 0;

  montador_operandos #(.NIBBLES(4)) dut (
    .clock(clock), .reset(reset), .limpa(limpa), .carrega_alvo(carrega_alvo),
    .alvo_in(alvo_in), .digito(digito), .digito_valido(digito_valido),
    .A(A), .B(B), .ALBi(ALBi), .AGBi(AGBi), .AEBi(AEBi),
    .pronto(pronto), .comparar(comparar), .contagem(contagem), .erro(erro)
  );

  always #5 clock = ~clock;

  // Advance one edge and settle; inputs change and outputs are sampled here
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    digito = d; digito_valido = 1'b1;
    step();
    digito_valido = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (A !== 16'h0) begin n_err++; $display("FAIL reset_A got %h exp %h", A, 16'h0); end
    n_cmp++; if (B !== 16'h0) begin n_err++; $display("FAIL reset_B got %h exp %h", B, 16'h0); end
    n_cmp++; if (contagem !== 3'd0) begin n_err++; $display("FAIL reset_contagem got %0d exp 0", contagem); end
    n_cmp++; if ({pronto, comparar, erro} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b exp 000", {pronto, comparar, erro}); end
    n_cmp++; if ({ALBi, AGBi, AEBi} !== 3'b001) begin n_err++; $display("FAIL cascade got %b exp 001", {ALBi, AGBi, AEBi}); end
    #10 reset = 1'b1;
    step();
  endtask

  task automatic test_normal_entry();
    carrega_alvo = 1'b1; alvo_in = 16'h1234;
    step();
    carrega_alvo = 1'b0;
    n_cmp++; if (B !== 16'h1234) begin n_err++; $display("FAIL normal_B got %h exp %h", B, 16'h1234); end
    n_cmp++; if ({pronto, comparar} !== 2'b00) begin n_err++; $display("FAIL normal_idle got %b exp 00", {pronto, comparar}); end
    send_digit(4'h1);
    send_digit(4'h2);
    n_cmp++; if (contagem !== 3'd2) begin n_err++; $display("FAIL normal_cnt2 got %0d exp 2", contagem); end
    send_digit(4'h3);
    n_cmp++; if ({pronto, comparar} !== 2'b00) begin n_err++; $display("FAIL normal_3dig got %b exp 00", {pronto, comparar}); end
    send_digit(4'h4);
    n_cmp++; if (A !== 16'h1234) begin n_err++; $display("FAIL normal_A got %h exp %h", A, 16'h1234); end
    n_cmp++; if (contagem !== 3'd4) begin n_err++; $display("FAIL normal_cnt4 got %0d exp 4", contagem); end
    n_cmp++; if ({pronto, comparar} !== 2'b11) begin n_err++; $display("FAIL normal_strobe got %b exp 11", {pronto, comparar}); end
    step();
    n_cmp++; if ({pronto, comparar} !== 2'b10) begin n_err++; $display("FAIL normal_strobe_end got %b exp 10", {pronto, comparar}); end
  endtask

  task automatic test_overflow();
    send_digit(4'hF);
    n_cmp++; if (A !== 16'h1234) begin n_err++; $display("FAIL ovf_A got %h exp %h", A, 16'h1234); end
    n_cmp++; if ({erro, comparar, pronto} !== 3'b101) begin n_err++; $display("FAIL ovf_flags got %b exp 101", {erro, comparar, pronto}); end
    step();
    n_cmp++; if (erro !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", erro); end
    limpa = 1'b1;
    step();
    limpa = 1'b0;
    n_cmp++; if ({A, contagem, erro, pronto, comparar} !== {16'h0, 3'd0, 3'b000}) begin n_err++; $display("FAIL ovf_limpa got A=%h cnt=%0d e/p/c=%b%b%b exp 0", A, contagem, erro, pronto, comparar); end
    n_cmp++; if (B !== 16'h1234) begin n_err++; $display("FAIL ovf_B_kept got %h exp %h", B, 16'h1234); end
  endtask

  task automatic test_reload();
    send_digit(4'h1); send_digit(4'h2); send_digit(4'h3); send_digit(4'h4);
    n_cmp++; if ({pronto, comparar} !== 2'b11) begin n_err++; $display("FAIL reload_first got %b exp 11", {pronto, comparar}); end
    step();
    carrega_alvo = 1'b1; alvo_in = 16'hFFFF;
    step();
    carrega_alvo = 1'b0;
    n_cmp++; if (B !== 16'hFFFF) begin n_err++; $display("FAIL reload_B got %h exp %h", B, 16'hFFFF); end
    n_cmp++; if ({pronto, comparar} !== 2'b11) begin n_err++; $display("FAIL reload_strobe got %b exp 11", {pronto, comparar}); end
    n_cmp++; if (A !== 16'h1234) begin n_err++; $display("FAIL reload_A got %h exp %h", A, 16'h1234); end
    step();
    n_cmp++; if (comparar !== 1'b0) begin n_err++; $display("FAIL reload_strobe_end got %b exp 0", comparar); end
    limpa = 1'b1;
    step();
    limpa = 1'b0;
    n_cmp++; if ({pronto, comparar} !== 2'b00) begin n_err++; $display("FAIL limpa_ready got %b exp 00", {pronto, comparar}); end
  endtask

  task automatic test_limpa_priority();
    send_digit(4'h1); send_digit(4'h2);
    n_cmp++; if (A !== 16'h0012) begin n_err++; $display("FAIL prio_pre_A got %h exp %h", A, 16'h0012); end
    limpa = 1'b1; digito = 4'h7; digito_valido = 1'b1;
    step();
    limpa = 1'b0; digito_valido = 1'b0;
    n_cmp++; if ({A, contagem, erro} !== {16'h0, 3'd0, 1'b0}) begin n_err++; $display("FAIL prio_clear got A=%h cnt=%0d erro=%b exp 0", A, contagem, erro); end
    n_cmp++; if (B !== 16'hFFFF) begin n_err++; $display("FAIL prio_B got %h exp %h", B, 16'hFFFF); end
  endtask

  task automatic test_reset_mid_entry();
    send_digit(4'h1); send_digit(4'h2);
    n_cmp++; if (contagem !== 3'd2) begin n_err++; $display("FAIL rmid_pre got %0d exp 2", contagem); end
    reset = 1'b0;
    #2;
    n_cmp++; if ({A, B} !== 32'h0) begin n_err++; $display("FAIL rmid_AB got A=%h B=%h exp 0", A, B); end
    n_cmp++; if ({contagem, pronto, comparar, erro} !== 6'b0) begin n_err++; $display("FAIL rmid_flags got cnt=%0d p/c/e=%b%b%b exp 0", contagem, pronto, comparar, erro); end
    #1 reset = 1'b1;
    step();
  endtask

  task automatic test_target_after_guess();
    send_digit(4'hA); send_digit(4'hB); send_digit(4'hC); send_digit(4'hD);
    n_cmp++; if (A !== 16'hABCD) begin n_err++; $display("FAIL late_A got %h exp %h", A, 16'hABCD); end
    n_cmp++; if ({pronto, comparar} !== 2'b00) begin n_err++; $display("FAIL late_nobtarget got %b exp 00", {pronto, comparar}); end
    step();
    n_cmp++; if ({pronto, comparar} !== 2'b00) begin n_err++; $display("FAIL late_wait got %b exp 00", {pronto, comparar}); end
    carrega_alvo = 1'b1; alvo_in = 16'h0005;
    step();
    carrega_alvo = 1'b0;
    n_cmp++; if (B !== 16'h0005) begin n_err++; $display("FAIL late_B got %h exp %h", B, 16'h0005); end
    n_cmp++; if ({pronto, comparar} !== 2'b11) begin n_err++; $display("FAIL late_strobe got %b exp 11", {pronto, comparar}); end
    step();
    n_cmp++; if ({pronto, comparar} !== 2'b10) begin n_err++; $display("FAIL late_strobe_end got %b exp 10", {pronto, comparar}); end
  endtask

  initial begin
    test_reset();
    test_normal_entry();
    test_overflow();
    test_reload();
    test_limpa_priority();
    test_reset_mid_entry();
    test_target_after_guess();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
